branch_unit_p: RTL and testbench
================================

// Module: branch_unit_p
// PURPOSE
//  Parametrised multi-cycle ARM7 branch execute unit: B, BL, and optionally BX (mode bit sets T state).
//  Sequences PC/Rm reads and LR/PC writes over the shared single-port register-file read/write interface.
//  Supports configurable RF read latency and pipeline PC offset, with busy/done handshake and a flush pulse.
//  Sits beside the ALU/LS units in execute; the decoder drives en/cond/link/bx/offset/rm.
// PARAMETERS
//  XLEN        32  datapath/address width
//  OFFSET_W    24  branch immediate width (word offset, signed)
//  RF_RD_LAT   1   cycles from read_en to valid read_value (>=1)
//  PC_AHEAD    8   pipeline PC bias added to the sampled r15
//  SUPPORT_BX  1   0: bx input ignored (treated as 0)
// PORTS
//  clk          in   1         clock
//  rst          in   1         async active-high reset
//  en           in   1         start pulse; accepted only when busy=0
//  cond         in   1         condition passed
//  link         in   1         BL: write return address to r14
//  bx           in   1         BX: target from rm, T bit = rm[0]
//  offset       in   OFFSET_W  signed word offset (B/BL)
//  rm           in   4         BX source register index
//  busy         out  1         op in flight
//  done         out  1         1-cycle pulse at completion
//  flush        out  1         1-cycle pulse when a taken branch writes r15
//  thumb_we     out  1         1-cycle pulse: update T bit
//  thumb_val    out  1         new T bit value
//  read_en      out  1         RF read strobe
//  read_reg     out  4         RF read index
//  read_value   in   XLEN      RF read data
//  write_en     out  1         RF write strobe
//  write_reg    out  4         RF write index
//  write_value  out  XLEN      RF write data
// BEHAVIOUR
//  Clock clk; reset rst is asynchronous, active-high. Reset: state IDLE; all outputs 0; captured regs 0.
//  All outputs are registered; a state's listed outputs are valid during that state's cycle.
//  IDLE: busy=0. en=1 -> capture cond/link/bx&SUPPORT_BX/offset/rm, go RD_PC. en while busy ignored.
//  RD_PC: read_en=1, read_reg=15 -> WAIT_PC.
//  WAIT_PC: read_en=0; counts RF_RD_LAT cycles; samples read_value at end of last -> pc.
//   Next: !cond -> WR_PC(pc+4); cond&link -> WR_LR; cond&bx -> RD_RM; else WR_PC(target).
//  WR_LR: write_en=1, write_reg=14, write_value=pc+PC_AHEAD-4. Next: bx ? RD_RM : WR_PC.
//  RD_RM/WAIT_RM: as RD_PC/WAIT_PC with read_reg=rm; sampled value -> rmv.
//  WR_PC: write_en=1, write_reg=15, value per BRANCH TARGET; flush=1 iff cond; thumb_we=1 iff cond&bx.
//  DONE: write_en=0, done=1, busy=1 -> IDLE (busy=0 next cycle; en may be accepted then).
//  busy=1 in every state except IDLE. read_en/write_en never both 1.
//  BRANCH TARGET: B/BL: pc+PC_AHEAD+(sext(offset,XLEN)<<2). BX: rmv & ~1, thumb_val=rmv[0].
//   Not taken: pc+4. All adds mod 2^XLEN (wrap, no flag).
//  Latency from accepting edge to done: B/not-taken RF_RD_LAT+3; BL +1; BX +RF_RD_LAT+1 more.
//  Reset mid-op: immediate IDLE, strobes drop; no partial write completes after reset.
//  BX with rm=15: reads r15 normally (no special case).
// STRUCTURE
//  Shared package arm7_pkg: REG_LR=4'd14, REG_PC=4'd15, branch FSM state encoding.
//  Sub-module branch_target: combinational target/LR/thumb computation from pc, rmv, offset, mode bits.
//  Top holds FSM, latency counter ($clog2(RF_RD_LAT+1) bits), capture regs, output regs.
// TESTING
//  B, cond=1, offset=24'h000010, r15=32'h1000 -> r15<=32'h1048, flush pulse, done at edge LAT+3, no r14 write.
//  BL, offset=24'hFFFFFE, r15=32'h1000 -> r14<=32'h1004 then r15<=32'h1000; flush=1.
//  cond=0, link=1 -> only r15<=32'h1004; no r14 write, flush=0, thumb_we=0.
//  BX rm=3, r3=32'h2001 -> r15<=32'h2000, thumb_we=1, thumb_val=1; repeat with RF_RD_LAT=3, latency grows by 2 per read.
//  en pulsed while busy -> ignored; rst asserted in WAIT_PC -> all outputs 0 same cycle, no write afterwards.
//  Wrap: r15=32'hFFFFFFF8, offset=0 -> r15<=32'h00000000.

Source files
------------

// File: rtl/arm7_pkg.sv
// rtl/arm7_pkg.sv - shared ARM7 register indices and branch FSM state encoding
package arm7_pkg;

    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_PC,
        ST_WAIT_PC,
        ST_WR_LR,
        ST_RD_RM,
        ST_WAIT_RM,
        ST_WR_PC,
        ST_DONE
    } br_state_t;

endpackage

// File: rtl/branch_unit_p_if.sv
// rtl/branch_unit_p_if.sv - decoder control plus register-file read/write bus of the branch unit
interface branch_unit_p_if #(
    parameter int XLEN     = 32,
    parameter int OFFSET_W = 24
);
    logic                en;
    logic                cond;
    logic                link;
    logic                bx;
    logic [OFFSET_W-1:0] offset;
    logic [3:0]          rm;
    logic                busy;
    logic                done;
    logic                flush;
    logic                thumb_we;
    logic                thumb_val;
    logic                read_en;
    logic [3:0]          read_reg;
    logic [XLEN-1:0]     read_value;
    logic                write_en;
    logic [3:0]          write_reg;
    logic [XLEN-1:0]     write_value;

    modport master (
        output en, cond, link, bx, offset, rm, read_value,
        input  busy, done, flush, thumb_we, thumb_val,
        input  read_en, read_reg, write_en, write_reg, write_value
    );

    modport slave (
        input  en, cond, link, bx, offset, rm, read_value,
        output busy, done, flush, thumb_we, thumb_val,
        output read_en, read_reg, write_en, write_reg, write_value
    );
endinterface

// File: rtl/branch_target.sv
// rtl/branch_target.sv - combinational branch target, link address and T-bit computation
module branch_target #(
    parameter int XLEN     = 32,
    parameter int OFFSET_W = 24,
    parameter int PC_AHEAD = 8
) (
    input  logic [XLEN-1:0]     i_pc,
    input  logic [XLEN-1:0]     i_rmv,
    input  logic [OFFSET_W-1:0] i_offset,
    input  logic                i_cond,
    input  logic                i_bx,
    output logic [XLEN-1:0]     o_target,
    output logic [XLEN-1:0]     o_lr,
    output logic                o_thumb
);
    localparam logic [XLEN-1:0] C_AHEAD = XLEN'(PC_AHEAD);
    localparam logic [XLEN-1:0] C_FOUR  = XLEN'(4);

    logic [XLEN-1:0] w_off_ext;

    assign w_off_ext = {{(XLEN-OFFSET_W){i_offset[OFFSET_W-1]}}, i_offset};

    // Not-taken falls through to the next instruction; all sums wrap silently.
    assign o_target = !i_cond ? i_pc + C_FOUR :
                      i_bx    ? {i_rmv[XLEN-1:1], 1'b0} :
                                i_pc + C_AHEAD + (w_off_ext << 2);
    assign o_lr     = i_pc + C_AHEAD - C_FOUR;
    assign o_thumb  = i_rmv[0];
endmodule

// File: rtl/branch_unit_p.sv
// rtl/branch_unit_p.sv - multi-cycle B/BL/BX execute unit sequencing RF reads and LR/PC writes
module branch_unit_p
    import arm7_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int OFFSET_W   = 24,
    parameter int RF_RD_LAT  = 1,
    parameter int PC_AHEAD   = 8,
    parameter int SUPPORT_BX = 1
) (
    input  logic           clk,
    input  logic           rst,
    branch_unit_p_if.slave bus
);
    localparam int              CNT_W    = $clog2(RF_RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RF_RD_LAT - 1);
    localparam logic            BX_EN    = (SUPPORT_BX != 0);

    br_state_t           r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_cond, r_link, r_bx;
    logic [OFFSET_W-1:0] r_offset;
    logic [3:0]          r_rm;
    logic [XLEN-1:0]     r_pc, r_rmv;
    logic                r_busy, r_done, r_flush, r_thumb_we, r_thumb_val;
    logic                r_read_en, r_write_en;
    logic [3:0]          r_read_reg, r_write_reg;
    logic [XLEN-1:0]     r_write_value;

    logic [XLEN-1:0]     w_pc, w_rmv, w_target, w_lr;
    logic                w_thumb;

    // On the sampling cycle the fresh read data bypasses the capture register.
    assign w_pc  = (r_state == ST_WAIT_PC) ? bus.read_value : r_pc;
    assign w_rmv = (r_state == ST_WAIT_RM) ? bus.read_value : r_rmv;

    branch_target #(
        .XLEN     (XLEN),
        .OFFSET_W (OFFSET_W),
        .PC_AHEAD (PC_AHEAD)
    ) u_target (
        .i_pc     (w_pc),
        .i_rmv    (w_rmv),
        .i_offset (r_offset),
        .i_cond   (r_cond),
        .i_bx     (r_bx),
        .o_target (w_target),
        .o_lr     (w_lr),
        .o_thumb  (w_thumb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_cond        <= 1'b0;
            r_link        <= 1'b0;
            r_bx          <= 1'b0;
            r_offset      <= '0;
            r_rm          <= '0;
            r_pc          <= '0;
            r_rmv         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_flush       <= 1'b0;
            r_thumb_we    <= 1'b0;
            r_thumb_val   <= 1'b0;
            r_read_en     <= 1'b0;
            r_read_reg    <= '0;
            r_write_en    <= 1'b0;
            r_write_reg   <= '0;
            r_write_value <= '0;
        end else begin
            r_read_en  <= 1'b0;
            r_write_en <= 1'b0;
            r_done     <= 1'b0;
            r_flush    <= 1'b0;
            r_thumb_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.en) begin
                        r_cond     <= bus.cond;
                        r_link     <= bus.link;
                        r_bx       <= bus.bx & BX_EN;
                        r_offset   <= bus.offset;
                        r_rm       <= bus.rm;
                        r_busy     <= 1'b1;
                        r_read_en  <= 1'b1;
                        r_read_reg <= REG_PC;
                        r_state    <= ST_RD_PC;
                    end
                end
                ST_RD_PC: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= ST_WAIT_PC;
                end
                ST_WAIT_PC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_pc <= bus.read_value;
                        if (r_cond && r_link) begin
                            r_write_en    <= 1'b1;
                            r_write_reg   <= REG_LR;
                            r_write_value <= w_lr;
                            r_state       <= ST_WR_LR;
                        end else if (r_cond && r_bx) begin
                            r_read_en  <= 1'b1;
                            r_read_reg <= r_rm;
                            r_state    <= ST_RD_RM;
                        end else begin
                            r_write_en    <= 1'b1;
                            r_write_reg   <= REG_PC;
                            r_write_value <= w_target;
                            r_flush       <= r_cond;
                            r_state       <= ST_WR_PC;
                        end
                    end
                end
                ST_WR_LR: begin
                    if (r_bx) begin
                        r_read_en  <= 1'b1;
                        r_read_reg <= r_rm;
                        r_state    <= ST_RD_RM;
                    end else begin
                        r_write_en    <= 1'b1;
                        r_write_reg   <= REG_PC;
                        r_write_value <= w_target;
                        r_flush       <= r_cond;
                        r_state       <= ST_WR_PC;
                    end
                end
                ST_RD_RM: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= ST_WAIT_RM;
                end
                ST_WAIT_RM: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rmv         <= bus.read_value;
                        r_write_en    <= 1'b1;
                        r_write_reg   <= REG_PC;
                        r_write_value <= w_target;
                        r_flush       <= r_cond;
                        r_thumb_we    <= r_cond & r_bx;
                        r_thumb_val   <= r_cond & r_bx & w_thumb;
                        r_state       <= ST_WR_PC;
                    end
                end
                ST_WR_PC: begin
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.flush       = r_flush;
    assign bus.thumb_we    = r_thumb_we;
    assign bus.thumb_val   = r_thumb_val;
    assign bus.read_en     = r_read_en;
    assign bus.read_reg    = r_read_reg;
    assign bus.write_en    = r_write_en;
    assign bus.write_reg   = r_write_reg;
    assign bus.write_value = r_write_value;
endmodule

// File: tb/tb_branch_unit_p.sv
// tb/tb_branch_unit_p.sv - randomized self-checking bench for branch_unit_p at read latencies 1 and 3
module tb_branch_unit_p;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        en = 1'b0, cond = 1'b0, link = 1'b0, bx = 1'b0;
    logic [23:0] offset = '0;
    logic [3:0]  rm = '0;
    logic [31:0] rv0 = '0, rv1 = '0;
    logic [31:0] rf [16];

    branch_unit_p_if #(.XLEN(32), .OFFSET_W(24)) b0 ();
    branch_unit_p_if #(.XLEN(32), .OFFSET_W(24)) b1 ();

    assign b0.en = en;  assign b0.cond = cond;  assign b0.link = link;
    assign b0.bx = bx;  assign b0.offset = offset;  assign b0.rm = rm;
    assign b1.en = en;  assign b1.cond = cond;  assign b1.link = link;
    assign b1.bx = bx;  assign b1.offset = offset;  assign b1.rm = rm;
    assign b0.read_value = rv0;
    assign b1.read_value = rv1;

    branch_unit_p #(.RF_RD_LAT(LAT0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
    branch_unit_p #(.RF_RD_LAT(LAT1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

    logic        m_we [2], m_re [2], m_flush [2], m_twe [2], m_tval [2], m_done [2], m_busy [2];
    logic [3:0]  m_wreg [2];
    logic [31:0] m_wval [2];
    assign m_we[0] = b0.write_en;    assign m_we[1] = b1.write_en;
    assign m_re[0] = b0.read_en;     assign m_re[1] = b1.read_en;
    assign m_flush[0] = b0.flush;    assign m_flush[1] = b1.flush;
    assign m_twe[0] = b0.thumb_we;   assign m_twe[1] = b1.thumb_we;
    assign m_tval[0] = b0.thumb_val; assign m_tval[1] = b1.thumb_val;
    assign m_done[0] = b0.done;      assign m_done[1] = b1.done;
    assign m_busy[0] = b0.busy;      assign m_busy[1] = b1.busy;
    assign m_wreg[0] = b0.write_reg; assign m_wreg[1] = b1.write_reg;
    assign m_wval[0] = b0.write_value; assign m_wval[1] = b1.write_value;

    int n_checks = 0;
    int n_fail = 0;
    int edge_no = 0;
    always @(posedge clk) edge_no++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Register-file model: data valid exactly on the LAT-th cycle after the strobe, garbage otherwise.
    logic [3:0] ridx0, ridx1;
    always begin
        @(negedge clk);
        if (b0.read_en && !rst) begin
            ridx0 = b0.read_reg;
            repeat (LAT0) @(posedge clk);
            #1 rv0 = rf[ridx0];
            @(posedge clk);
            #1 rv0 = $urandom;
        end
    end
    always begin
        @(negedge clk);
        if (b1.read_en && !rst) begin
            ridx1 = b1.read_reg;
            repeat (LAT1) @(posedge clk);
            #1 rv1 = rf[ridx1];
            @(posedge clk);
            #1 rv1 = $urandom;
        end
    end

    int          wr_cnt [2], flush_cnt [2], flush_bad [2], thumb_cnt [2], done_cnt [2], done_edge [2], both_cnt [2];
    logic [3:0]  wr_reg [2][4];
    logic [31:0] wr_val [2][4];
    logic        thumb_v [2];

    task automatic clear_records();
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d] = 0; flush_cnt[d] = 0; flush_bad[d] = 0; thumb_cnt[d] = 0;
            done_cnt[d] = 0; done_edge[d] = 0; both_cnt[d] = 0; thumb_v[d] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (m_we[d]) begin
                    if (wr_cnt[d] < 4) begin
                        wr_reg[d][wr_cnt[d]] = m_wreg[d];
                        wr_val[d][wr_cnt[d]] = m_wval[d];
                    end
                    wr_cnt[d]++;
                end
                if (m_flush[d]) begin
                    flush_cnt[d]++;
                    if (!(m_we[d] && m_wreg[d] == 4'd15)) flush_bad[d]++;
                end
                if (m_twe[d]) begin
                    thumb_cnt[d]++;
                    thumb_v[d] = m_tval[d];
                end
                if (m_done[d]) begin
                    done_cnt[d]++;
                    done_edge[d] = edge_no;
                end
                if (m_re[d] && m_we[d]) both_cnt[d]++;
            end
        end
    end

    task automatic run_op(input logic c, input logic lk, input logic x, input logic [23:0] off,
                          input logic [3:0] r, input logic [31:0] pcv, input logic [31:0] rmval,
                          input logic poke);
        int          acc, exp_n, lat_exp, lats [2];
        logic [3:0]  e_reg [2];
        logic [31:0] e_val [2], rmv;
        int          soff;
        lats[0] = LAT0;
        lats[1] = LAT1;
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        rf[r]  = rmval;
        rf[15] = pcv;
        rmv    = rf[r];
        soff   = int'($signed(off));
        exp_n = 0;
        if (c && lk) begin
            e_reg[exp_n] = 4'd14; e_val[exp_n] = pcv + 32'd4; exp_n++;
        end
        e_reg[exp_n] = 4'd15;
        if (!c)      e_val[exp_n] = pcv + 32'd4;
        else if (x)  e_val[exp_n] = {rmv[31:1], 1'b0};
        else         e_val[exp_n] = pcv + 32'd8 + 32'(soff * 4);
        exp_n++;

        @(posedge clk); #2;
        clear_records();
        cond = c; link = lk; bx = x; offset = off; rm = r; en = 1'b1;
        acc = edge_no + 1;
        @(posedge clk); #2;
        en = 1'b0;
        if (poke) begin
            @(posedge clk); #2;
            en = 1'b1; cond = ~c; link = ~lk; bx = ~x; offset = ~off; rm = ~r;
            @(posedge clk); #2;
            en = 1'b0;
        end
        for (int k = 0; k < 80 && !(done_cnt[0] > 0 && done_cnt[1] > 0); k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        check("timeout", 64'(done_cnt[0] > 0 && done_cnt[1] > 0), 64'd1);
        for (int d = 0; d < 2; d++) begin
            lat_exp = lats[d] + 3 + ((c && lk) ? 1 : 0) + ((c && x) ? lats[d] + 1 : 0);
            check($sformatf("lat%0d", d), 64'(done_edge[d] - acc + 1), 64'(lat_exp));
            check($sformatf("done_cnt%0d", d), 64'(done_cnt[d]), 64'd1);
            check($sformatf("wr_cnt%0d", d), 64'(wr_cnt[d]), 64'(exp_n));
            for (int i = 0; i < exp_n && i < wr_cnt[d]; i++) begin
                check($sformatf("wr_reg%0d_%0d", d, i), 64'(wr_reg[d][i]), 64'(e_reg[i]));
                check($sformatf("wr_val%0d_%0d", d, i), 64'(wr_val[d][i]), 64'(e_val[i]));
            end
            check($sformatf("flush%0d", d), 64'(flush_cnt[d]), c ? 64'd1 : 64'd0);
            check($sformatf("flush_pos%0d", d), 64'(flush_bad[d]), 64'd0);
            check($sformatf("thumb_we%0d", d), 64'(thumb_cnt[d]), (c && x) ? 64'd1 : 64'd0);
            if (c && x) check($sformatf("thumb_val%0d", d), 64'(thumb_v[d]), 64'(rmv[0]));
            check($sformatf("rw_excl%0d", d), 64'(both_cnt[d]), 64'd0);
            check($sformatf("busy_end%0d", d), 64'(m_busy[d]), 64'd0);
        end
    endtask

    task automatic reset_mid_op();
        @(posedge clk); #2;
        clear_records();
        rf[15] = 32'h0000_1000;
        cond = 1'b1; link = 1'b1; bx = 1'b0; offset = 24'h10; rm = 4'd0; en = 1'b1;
        @(posedge clk); #2;
        en = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_outs0", {b0.busy, b0.done, b0.flush, b0.thumb_we, b0.thumb_val, b0.read_en,
                            b0.read_reg, b0.write_en, b0.write_reg, b0.write_value}, 64'd0);
        check("rst_outs1", {b1.busy, b1.done, b1.flush, b1.thumb_we, b1.thumb_val, b1.read_en,
                            b1.read_reg, b1.write_en, b1.write_reg, b1.write_value}, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        clear_records();
        repeat (12) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("post_rst_wr%0d", d), 64'(wr_cnt[d]), 64'd0);
            check($sformatf("post_rst_done%0d", d), 64'(done_cnt[d]), 64'd0);
            check($sformatf("post_rst_busy%0d", d), 64'(m_busy[d]), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = '0;
        clear_records();
        repeat (2) @(posedge clk);
        #2;
        check("reset0", {b0.busy, b0.done, b0.flush, b0.thumb_we, b0.thumb_val, b0.read_en,
                         b0.read_reg, b0.write_en, b0.write_reg, b0.write_value}, 64'd0);
        check("reset1", {b1.busy, b1.done, b1.flush, b1.thumb_we, b1.thumb_val, b1.read_en,
                         b1.read_reg, b1.write_en, b1.write_reg, b1.write_value}, 64'd0);
        rst = 1'b0;

        run_op(1'b1, 1'b0, 1'b0, 24'h000010, 4'd0,  32'h0000_1000, 32'h0, 1'b0);
        run_op(1'b1, 1'b1, 1'b0, 24'hFFFFFE, 4'd0,  32'h0000_1000, 32'h0, 1'b0);
        run_op(1'b0, 1'b1, 1'b0, 24'h000123, 4'd0,  32'h0000_1000, 32'h0, 1'b0);
        run_op(1'b1, 1'b0, 1'b1, 24'h000000, 4'd3,  32'h0000_1000, 32'h0000_2001, 1'b0);
        run_op(1'b1, 1'b1, 1'b1, 24'h000000, 4'd3,  32'h0000_1000, 32'h0000_2001, 1'b0);
        run_op(1'b1, 1'b0, 1'b1, 24'h000000, 4'd15, 32'h0000_3003, 32'h0000_3003, 1'b0);
        run_op(1'b1, 1'b0, 1'b0, 24'h000000, 4'd0,  32'hFFFF_FFF8, 32'h0, 1'b0);
        run_op(1'b1, 1'b0, 1'b0, 24'h000010, 4'd0,  32'h0000_1000, 32'h0, 1'b1);
        reset_mid_op();

        for (int n = 0; n < 40; n++) begin
            logic [3:0]  r;
            logic [31:0] pcv, rmval;
            r     = 4'($urandom_range(0, 15));
            pcv   = $urandom;
            rmval = (r == 4'd15) ? pcv : $urandom;
            run_op(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   24'($urandom), r, pcv, rmval, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
